moore_sequence_detector_nol: RTL and testbench



---
 rtl/moore_sequence_detector_nol.sv | 88 ++++++++
 tb/tb_moore_sequence_detector_nol.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/moore_sequence_detector_nol.sv
// -----------------------------------------------------------------------------
// moore_sequence_detector_nol
//
// Moore FSM that watches a serial bit stream (one bit per rising clk edge) and
// raises z for exactly one clock period after the edge that samples the last
// bit of the pattern 1001. Matching is non-overlapping: the bits that complete
// a match are consumed, so the final 1 of a match never starts the next one.
//
// There is no handshake. Every rising edge of clk consumes one bit of x, and
// z is valid for the whole clock period that follows that edge.
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   rst       in   1  asynchronous active-low reset (0 = hold in S0, z = 0)
//   x         in   1  serial data bit, sampled on each rising clk edge
//   z         out  1  pattern-found flag, 1 only while in the DETECT state
//   state_dbg out  3  raw state register, for debug visibility only
// -----------------------------------------------------------------------------
module moore_sequence_detector_nol (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic       z,
    output logic [2:0] state_dbg
);

    // Each state name records how much of 1001 has been seen so far.
    typedef enum logic [2:0] {
        S0     = 3'd0,
        S1     = 3'd1,
        S10    = 3'd2,
        S100   = 3'd3,
        DETECT = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // State register. Reset is asynchronous, so a reset arriving while z is
    // high clears it at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = S0;
        case (state)
            S0: begin
                state_next = x ? S1 : S0;
            end
            S1: begin
                // A repeated 1 is itself a fresh prefix, so stay in S1.
                state_next = x ? S1 : S10;
            end
            S10: begin
                // "101": the newest 1 restarts the attempt.
                state_next = x ? S1 : S100;
            end
            S100: begin
                // "1000" shares no prefix with 1001, so go back to idle.
                state_next = x ? DETECT : S0;
            end
            DETECT: begin
                // The completed match is consumed: this behaves like S0,
                // so the final 1 of the match is never reused.
                state_next = x ? S1 : S0;
            end
            default: begin
                // Unused encodings recover to idle on the next edge.
                state_next = S0;
            end
        endcase
    end

    // Output decode: a pure function of the state register, with no path
    // from x.
    always_comb begin
        z = (state == DETECT);
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_moore_sequence_detector_nol.sv
// -----------------------------------------------------------------------------
// Bench for moore_sequence_detector_nol.
//
// Timing: x changes on the falling edge, the DUT samples it on the next rising
// edge, and the monitor reads z 1 ns after that rising edge. Reset is asserted
// and released between edges.
// -----------------------------------------------------------------------------
module tb_moore_sequence_detector_nol;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x   = 1'b0;
    logic       z;
    logic [2:0] state_dbg;

    int tests = 0;
    int fails = 0;

    // Expected z after each sampled bit, in the order the bits are driven.
    logic [0:0] exp_q[$];
    // Reference model: the bits seen since reset or since the last match.
    bit         hist_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    moore_sequence_detector_nol dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .z         (z),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: z=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a match is any time the four most recent unconsumed
    // bits read 1,0,0,1. A match consumes every bit seen so far.
    task automatic model_push(input bit b);
        int n;
        logic [0:0] e;
        hist_q.push_back(b);
        n = hist_q.size();
        e = 1'b0;
        if (n >= 4) begin
            if (hist_q[n-4] == 1'b1 && hist_q[n-3] == 1'b0 &&
                hist_q[n-2] == 1'b0 && hist_q[n-1] == 1'b1) begin
                e = 1'b1;
                hist_q.delete();
            end
        end
        exp_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin : monitor
        logic [0:0] e;
        #1;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("z_after_bit", z, e[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input bit b);
        @(negedge clk);
        x = b;
        model_push(b);
    endtask

    // Drive len bits of pattern, most significant bit first.
    task automatic drive_seq(input logic [31:0] pattern, input int len);
        logic [31:0] p;
        p = pattern;
        for (int i = len - 1; i >= 0; i--) begin
            drive_bit(p[i]);
        end
    endtask

    // Wait, for a bounded number of cycles, until every driven bit has been
    // checked. Ends 2 ns after a rising edge, which is between edges.
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Assert reset between edges, hold it for the given number of rising edges
    // while x toggles, then release it between edges with x = 0.
    task automatic apply_reset(input int edges);
        wait_drain();
        rst = 1'b0;
        #1;
        check("z_async_reset", z, 1'b0);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            x = 1'($urandom_range(0, 1));
            check("z_in_reset", z, 1'b0);
        end
        @(negedge clk);
        x = 1'b0;
        #2;
        rst = 1'b1;
        hist_q.delete();
        // The next rising edge samples this x = 0.
        model_push(1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        // Test 1: reset with x toggling, release with x = 0.
        apply_reset(4);
        drive_seq(32'b0000, 4);

        // Test 2: single match, then a 0 to see z fall after one cycle.
        drive_seq(32'b10010, 5);

        // Test 3: non-overlap; pulses after the 4th and 10th bits only.
        drive_seq(32'b10010010010, 11);

        // Test 4: prefix handling.
        apply_reset(1);
        drive_seq(32'b1001001110110, 13);
        apply_reset(1);
        drive_seq(32'b110010, 6);

        // Test 5: near misses.
        apply_reset(1);
        drive_seq(32'b1010010, 7);
        apply_reset(1);
        drive_seq(32'b100010, 6);

        // Test 6a: reset in the middle of a partial match, then 1,0,0,1 must
        // still need all four bits after the reset.
        apply_reset(1);
        drive_seq(32'b100, 3);
        apply_reset(1);
        drive_seq(32'b10010, 5);

        // Test 6b: reset while z is high drops z without a clock edge.
        apply_reset(1);
        drive_seq(32'b1001, 4);
        wait_drain();
        check("z_high_before_reset", z, 1'b1);
        apply_reset(2);
        drive_seq(32'b0, 1);

        // Randomised stream with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset(int'($urandom_range(1, 3)));
            end
            drive_bit(1'($urandom_range(0, 1)));
        end

        wait_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
